// File: rtl/tri_fetcher_if.sv
// rtl/tri_fetcher_if.sv - triangle stream and Avalon-MM read master bundle
interface tri_fetcher_if #(
   parameter int WORDS_PER_TRI = 9
) ();
   logic                        avm_m0_read;
   logic [31:0]                 avm_m0_address;
   logic [1:0]                  avm_m0_byteenable;
   logic [15:0]                 avm_m0_readdata;
   logic                        avm_m0_readdatavalid;
   logic                        avm_m0_waitrequest;
   logic [32*WORDS_PER_TRI-1:0] o_tri;
   logic [31:0]                 o_tri_index;
   logic                        o_valid;
   logic                        i_ready;

   modport master (
      output avm_m0_read, avm_m0_address, avm_m0_byteenable,
      input  avm_m0_readdata, avm_m0_readdatavalid, avm_m0_waitrequest,
      output o_tri, o_tri_index, o_valid,
      input  i_ready
   );

   modport slave (
      input  avm_m0_read, avm_m0_address, avm_m0_byteenable,
      output avm_m0_readdata, avm_m0_readdatavalid, avm_m0_waitrequest,
      input  o_tri, o_tri_index, o_valid,
      output i_ready
   );
endinterface

// File: rtl/tri_fetcher.sv
// rtl/tri_fetcher.sv - streams triangle records from SDRAM via pipelined halfword reads
module tri_fetcher #(
   parameter int WORDS_PER_TRI = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_start,
   input  logic [31:0]   i_baseaddr,
   input  logic [31:0]   i_tri_cnt,
   output logic          o_busy,
   output logic          o_done,
   tri_fetcher_if.master bus
);
   localparam int          HW_PER_TRI = 2 * WORDS_PER_TRI;
   localparam logic [4:0]  LAST_HW    = 5'(HW_PER_TRI - 1);
   localparam logic [31:0] TRI_BYTES  = 32'(4 * WORDS_PER_TRI);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ISSUE   = 3'd1;
   localparam logic [2:0] DRAIN   = 3'd2;
   localparam logic [2:0] PRESENT = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   logic [2:0]  state;
   logic [31:0] tri_addr;
   logic [31:0] cnt;
   logic [31:0] index;
   logic [4:0]  issued;
   logic [4:0]  recv;
   logic [15:0] hw_buf [HW_PER_TRI];

   logic in_issue;
   logic accept;
   logic capture;

   assign in_issue = (state == ISSUE);
   assign accept   = in_issue && !bus.avm_m0_waitrequest;
   // Responses outside ISSUE/DRAIN are stale (e.g. left over from a reset) and dropped.
   assign capture  = ((state == ISSUE) || (state == DRAIN)) && bus.avm_m0_readdatavalid
                     && (recv <= LAST_HW);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tri_addr <= '0;
         cnt      <= '0;
         index    <= '0;
         issued   <= '0;
         recv     <= '0;
         for (int k = 0; k < HW_PER_TRI; k++) begin
            hw_buf[k] <= '0;
         end
      end else begin
         if (capture) begin
            hw_buf[recv] <= bus.avm_m0_readdata;
            recv         <= recv + 5'd1;
         end
         case (state)
            IDLE: begin
               if (i_start) begin
                  tri_addr <= i_baseaddr;
                  cnt      <= i_tri_cnt;
                  index    <= '0;
                  issued   <= '0;
                  recv     <= '0;
                  state    <= (i_tri_cnt == 32'd0) ? DONE : ISSUE;
               end
            end
            ISSUE: begin
               if (accept) begin
                  issued <= issued + 5'd1;
                  if (issued == LAST_HW) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (capture && (recv == LAST_HW)) state <= PRESENT;
            end
            PRESENT: begin
               if (bus.i_ready) begin
                  if (index == cnt - 32'd1) begin
                     state <= DONE;
                  end else begin
                     index    <= index + 32'd1;
                     tri_addr <= tri_addr + TRI_BYTES;
                     issued   <= '0;
                     recv     <= '0;
                     state    <= ISSUE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Address is derived from registered state only, so it holds steady under waitrequest.
   assign bus.avm_m0_read       = in_issue;
   assign bus.avm_m0_address    = in_issue ? (tri_addr + {26'd0, issued, 1'b0}) : 32'd0;
   assign bus.avm_m0_byteenable = in_issue ? 2'b11 : 2'b00;

   for (genvar g = 0; g < HW_PER_TRI; g++) begin : g_tri
      assign bus.o_tri[16*g +: 16] = hw_buf[g];
   end

   assign bus.o_tri_index = index;
   assign bus.o_valid     = (state == PRESENT);
   assign o_busy          = (state != IDLE);
   assign o_done          = (state == DONE);
endmodule

// File: tb/tb_tri_fetcher.sv
// tb/tb_tri_fetcher.sv - directed self-checking bench for tri_fetcher
module tb_tri_fetcher;
   logic        clk        = 1'b1;
   logic        reset      = 1'b1;
   logic        i_start    = 1'b0;
   logic [31:0] i_baseaddr = '0;
   logic [31:0] i_tri_cnt  = '0;
   logic        o_busy;
   logic        o_done;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;
   int unsigned t0     = 0;

   typedef struct {
      int unsigned due;
      logic [15:0] data;
   } resp_t;

   resp_t       rq[$];
   logic [31:0] acc_addrs[$];
   int          acc_count    = 0;
   int          wr_pct       = 0;
   int unsigned lat_min      = 2;
   int unsigned lat_max      = 2;
   int          stale_pulses = 0;
   int unsigned last_due     = 0;
   logic        prev_stall   = 1'b0;
   logic [31:0] prev_addr    = '0;
   logic [1:0]  prev_be      = '0;
   logic        read_seen    = 1'b0;
   logic        valid_seen   = 1'b0;

   tri_fetcher_if #(.WORDS_PER_TRI(9)) bus ();

   tri_fetcher #(.WORDS_PER_TRI(9)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_start   (i_start),
      .i_baseaddr(i_baseaddr),
      .i_tri_cnt (i_tri_cnt),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .bus       (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Avalon slave model: memory halfword at byte a is a[15:0]; in-order responses.
   always @(negedge clk) begin
      int unsigned lat;
      int unsigned due;
      logic        wr;
      if (prev_stall && !reset) begin
         checks++;
         assert (bus.avm_m0_read === 1'b1 && bus.avm_m0_address === prev_addr &&
                 bus.avm_m0_byteenable === prev_be)
         else begin
            errors++;
            $error("FAIL stall_hold: observed read=%0b addr=%08h be=%0b expected read=1 addr=%08h be=%0b",
                   bus.avm_m0_read, bus.avm_m0_address, bus.avm_m0_byteenable, prev_addr, prev_be);
         end
      end
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         bus.avm_m0_readdatavalid = 1'b1;
         bus.avm_m0_readdata      = rq[0].data;
         void'(rq.pop_front());
      end else if (stale_pulses > 0) begin
         bus.avm_m0_readdatavalid = 1'b1;
         bus.avm_m0_readdata      = 16'hDEAD;
         stale_pulses--;
      end else begin
         bus.avm_m0_readdatavalid = 1'b0;
         bus.avm_m0_readdata      = 16'h5A5A;
      end
      wr = (wr_pct > 0) && ($urandom_range(99, 0) < 32'(wr_pct));
      bus.avm_m0_waitrequest = wr;
      if (bus.avm_m0_read === 1'b1) read_seen = 1'b1;
      if (bus.o_valid === 1'b1) valid_seen = 1'b1;
      if (bus.avm_m0_read === 1'b1 && !wr && !reset) begin
         acc_count++;
         acc_addrs.push_back(bus.avm_m0_address);
         lat = $urandom_range(lat_max, lat_min);
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         rq.push_back('{due, bus.avm_m0_address[15:0]});
      end
      prev_stall = (bus.avm_m0_read === 1'b1) && wr && !reset;
      prev_addr  = bus.avm_m0_address;
      prev_be    = bus.avm_m0_byteenable;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic chk_tri(input string tag, input logic [287:0] obs, input logic [287:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %072h expected %072h", tag, obs, exp);
      end
   endtask

   function automatic logic [287:0] exp_tri(input logic [31:0] base);
      logic [287:0] r;
      logic [31:0]  a;
      for (int k = 0; k < 18; k++) begin
         a = base + 32'(2 * k);
         r[16*k +: 16] = a[15:0];
      end
      return r;
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic start_run(input logic [31:0] base, input logic [31:0] n);
      i_baseaddr = base;
      i_tri_cnt  = n;
      i_start    = 1'b1;
      t0         = cyc;
      step();
      i_start    = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int budget, output int unsigned rel);
      int n = 0;
      while (bus.o_valid !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      chk(tag, 32'(bus.o_valid), 32'd1);
      rel = cyc - t0;
   endtask

   task automatic accept_tri(input string tag, input logic [31:0] idx, input logic [287:0] exp);
      chk_tri({tag, "_data"}, bus.o_tri, exp);
      chk({tag, "_index"}, bus.o_tri_index, idx);
      bus.i_ready = 1'b1;
      step();
      bus.i_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(bus.o_valid), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_done"}, 32'(o_done), 32'd0);
      chk({tag, "_read"}, 32'(bus.avm_m0_read), 32'd0);
      chk({tag, "_addr"}, bus.avm_m0_address, 32'd0);
      chk({tag, "_be"}, 32'(bus.avm_m0_byteenable), 32'd0);
      chk({tag, "_index"}, bus.o_tri_index, 32'd0);
      chk_tri({tag, "_tri"}, bus.o_tri, 288'd0);
   endtask

   initial begin
      int unsigned rel;
      int          base_acc;
      int          n;
      logic        bad;
      bus.i_ready              = 1'b0;
      bus.avm_m0_waitrequest   = 1'b0;
      bus.avm_m0_readdatavalid = 1'b0;
      bus.avm_m0_readdata      = 16'h0;

      // Reset state
      repeat (3) step();
      chk_all_zero("reset");
      reset = 1'b0;
      step();

      // Zero count: done at cycle 1, no traffic
      read_seen  = 1'b0;
      valid_seen = 1'b0;
      start_run(32'h1C, 32'd0);
      chk("zero_done_c1", 32'(o_done), 32'd1);
      chk("zero_rel", cyc - t0, 32'd1);
      step();
      chk("zero_done_drop", 32'(o_done), 32'd0);
      chk("zero_busy_drop", 32'(o_busy), 32'd0);
      chk("zero_no_read", 32'(read_seen), 32'd0);
      chk("zero_no_valid", 32'(valid_seen), 32'd0);

      // Single triangle, no stalls, L=2
      acc_addrs.delete();
      lat_min = 2;
      lat_max = 2;
      start_run(32'h1C, 32'd1);
      chk("single_read_c1", 32'(bus.avm_m0_read), 32'd1);
      chk("single_be", 32'(bus.avm_m0_byteenable), 32'd3);
      wait_valid("single_valid", 100, rel);
      chk("single_valid_cycle", rel, 32'd21);
      chk("single_word0", bus.o_tri[31:0], 32'h001E001C);
      accept_tri("single", 32'd0, exp_tri(32'h1C));
      chk("single_done", 32'(o_done), 32'd1);
      step();
      chk("single_busy_low", 32'(o_busy), 32'd0);
      chk("single_nreads", 32'(acc_addrs.size()), 32'd18);
      bad = 1'b0;
      for (int k = 0; k < acc_addrs.size(); k++)
         if (acc_addrs[k] !== 32'h1C + 32'(2 * k)) bad = 1'b1;
      chk("single_addr_seq", 32'(bad), 32'd0);

      // Waitrequest stress, cnt=3
      base_acc = acc_count;
      wr_pct   = 50;
      lat_min  = 1;
      lat_max  = 5;
      start_run(32'h1C, 32'd3);
      for (int t = 0; t < 3; t++) begin
         wait_valid("stress_valid", 400, rel);
         accept_tri("stress", 32'(t), exp_tri(32'h1C + 32'(36 * t)));
      end
      chk("stress_done", 32'(o_done), 32'd1);
      chk("stress_nreads", 32'(acc_count - base_acc), 32'd54);
      wr_pct = 0;
      step();

      // Backpressure on triangle 1 of 2
      lat_min = 2;
      lat_max = 2;
      start_run(32'h1C, 32'd2);
      wait_valid("bp_valid0", 100, rel);
      accept_tri("bp_t0", 32'd0, exp_tri(32'h1C));
      wait_valid("bp_valid1", 100, rel);
      base_acc = acc_count;
      bad = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (bus.o_valid !== 1'b1 || bus.o_tri_index !== 32'd1 ||
             bus.o_tri !== exp_tri(32'h40) || bus.avm_m0_read !== 1'b0) bad = 1'b1;
      end
      chk("bp_hold_stable", 32'(bad), 32'd0);
      chk("bp_no_reads", 32'(acc_count - base_acc), 32'd0);
      accept_tri("bp_t1", 32'd1, exp_tri(32'h40));
      chk("bp_done", 32'(o_done), 32'd1);
      step();
      chk("bp_busy_low", 32'(o_busy), 32'd0);

      // Reset mid-run with stale responses afterwards
      lat_min  = 5;
      lat_max  = 5;
      base_acc = acc_count;
      start_run(32'h1C, 32'd2);
      n = 0;
      while (acc_count - base_acc < 7 && n < 50) begin
         step();
         n++;
      end
      chk("rst_seven_reads", 32'(acc_count - base_acc >= 7), 32'd1);
      reset = 1'b1;
      step();
      chk_all_zero("rst_mid");
      step();
      reset        = 1'b0;
      stale_pulses = 3;
      bad          = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (o_busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.avm_m0_read !== 1'b0) bad = 1'b1;
      end
      chk("rst_stale_idle", 32'(bad), 32'd0);
      chk_tri("rst_stale_buf", bus.o_tri, 288'd0);
      chk("rst_stale_drained", 32'(rq.size() + stale_pulses), 32'd0);
      start_run(32'h200, 32'd1);
      wait_valid("rst_restart_valid", 100, rel);
      accept_tri("rst_restart", 32'd0, exp_tri(32'h200));
      chk("rst_restart_done", 32'(o_done), 32'd1);
      step();

      // Start while busy plus address wrap
      acc_addrs.delete();
      lat_min = 3;
      lat_max = 3;
      start_run(32'hFFFF_FFF8, 32'd1);
      step();
      step();
      i_baseaddr = 32'h1000;
      i_tri_cnt  = 32'd5;
      i_start    = 1'b1;
      step();
      i_start    = 1'b0;
      wait_valid("wrap_valid", 100, rel);
      accept_tri("wrap", 32'd0, exp_tri(32'hFFFF_FFF8));
      chk("wrap_done", 32'(o_done), 32'd1);
      step();
      chk("wrap_busy_low", 32'(o_busy), 32'd0);
      chk("wrap_nreads", 32'(acc_addrs.size()), 32'd18);
      bad = 1'b0;
      for (int k = 0; k < acc_addrs.size(); k++)
         if (acc_addrs[k] !== 32'hFFFF_FFF8 + 32'(2 * k)) bad = 1'b1;
      chk("wrap_addr_seq", 32'(bad), 32'd0);
      if (acc_addrs.size() > 4) chk("wrap_addr4", acc_addrs[4], 32'h0000_0000);
      if (acc_addrs.size() > 17) chk("wrap_addr17", acc_addrs[17], 32'h0000_001A);
      valid_seen = 1'b0;
      repeat (5) step();
      chk("wrap_no_extra_run", 32'(valid_seen | o_busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tri_fetcher.md
# tri_fetcher

Streams triangle records from SDRAM to the intersection datapath over a 16-bit Avalon-MM read master. It is started with a base address and a triangle count by the top-level ray-tracing controller. It reads each 9-word (36-byte) triangle as 18 pipelined halfword reads and assembles them into a 288-bit record. It then presents the record, with its index, on a valid/ready stream to the downstream intersection unit.

## Interface
- `WORDS_PER_TRI`, default 9: 32-bit words per triangle (v0.xyz, v1.xyz, v2.xyz); HW_PER_TRI = 2*WORDS_PER_TRI.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `i_start` in 1: one-cycle start pulse; ignored unless state is IDLE.
- `i_baseaddr` in 32: byte address of triangle 0; bit 0 must be 0.
- `i_tri_cnt` in 32: number of triangles to stream.
- `o_tri` out 288: assembled triangle; word w = o_tri[32w+31:32w].
- `o_tri_index` out 32: index of the triangle on o_tri, 0-based.
- `o_valid` out 1: o_tri/o_tri_index valid.
- `i_ready` in 1: downstream accepts when o_valid && i_ready.
- `o_busy` out 1: high in every state except IDLE.
- `o_done` out 1: one-cycle pulse when the run completes.
- `avm_m0_read` out 1, `avm_m0_address` out 32, `avm_m0_byteenable` out 2, `avm_m0_readdata` in 16, `avm_m0_readdatavalid` in 1, `avm_m0_waitrequest` in 1: Avalon-MM pipelined read master.

## Operation
- States: IDLE, ISSUE, DRAIN, PRESENT, DONE.
- IDLE, on i_start:
  - Latch base into `tri_addr` and latch `i_tri_cnt`.
  - Clear index, `issued` and `recv`.
  - Go to DONE if i_tri_cnt==0, else ISSUE.
- ISSUE:
  - Drive avm_m0_read=1, avm_m0_address = tri_addr + 2*issued, byteenable=2'b11.
  - A read is accepted in any cycle with read && !waitrequest; `issued` increments on acceptance.
  - After acceptance with issued==HW_PER_TRI-1, go to DRAIN.
- Data capture (ISSUE and DRAIN):
  - On readdatavalid, write readdata into halfword slot `recv` and increment `recv`.
  - Slot k maps to o_tri[16k+15:16k], so word w = {hw[2w+1], hw[2w]} (little-endian).
- DRAIN: read deasserted. When recv reaches HW_PER_TRI, go to PRESENT.
- PRESENT:
  - o_valid=1; o_tri and o_tri_index held stable until accepted.
  - On acceptance, if index == cnt-1 go to DONE.
  - Otherwise increment index, set tri_addr += 4*WORDS_PER_TRI, clear `issued`/`recv`, and go to ISSUE.
- DONE: o_done=1 for one cycle, then go to IDLE.
- Address arithmetic is 32-bit modulo 2^32; no range checks are performed.
- Counters: `issued`/`recv` are 5 bits; index and cnt are 32 bits.
- readdatavalid in IDLE, PRESENT or DONE is ignored. This covers stale responses after a reset; software reissues i_start after reset.
- The block never has more than HW_PER_TRI reads outstanding. The buffer is never overwritten while o_valid=1.

## Timing
- Reset: state IDLE; all outputs 0 (o_tri, o_tri_index, o_valid, o_busy, o_done, avm_m0_read, avm_m0_address, avm_m0_byteenable); counters cleared.
- Reset mid-operation drops read in the next cycle, with no completion of pending reads.
- i_start sampled at cycle 0 ⇒ ISSUE and first read asserted at cycle 1.
- avm_m0_read, avm_m0_address and avm_m0_byteenable are held constant while waitrequest=1.
- With waitrequest=0 and fixed read latency L:
  - Reads are accepted in cycles 1..18 and the last data arrives at 18+L.
  - o_valid rises at cycle 19+L.
- o_valid rises the cycle after the 18th readdatavalid and falls the cycle after acceptance. There are no back-to-back valid triangles.
- Acceptance of the last triangle at cycle T ⇒ o_done at T+1 and o_busy=0 at T+2.
- i_cnt=0: i_start at 0 ⇒ o_done at 1, no Avalon traffic.
- readdatavalid arriving in the same cycle as a read acceptance is handled; both counters advance.

## Test plan
- Zero count:
  - Stimulus: base=0x1C, cnt=0, start.
  - Required: o_done at cycle 1, avm_m0_read never asserted, o_valid never asserted.
- Single triangle, no stalls, L=2:
  - Stimulus: base=0x1C, memory halfword at byte a = a[15:0].
  - Required: addresses 0x1C..0x3E step 2; o_valid at cycle 21; word0 = 0x001E001C; index 0; o_done after i_ready.
- Waitrequest stress:
  - Stimulus: random waitrequest (50%), random latency 1-5, cnt=3, base=0x1C.
  - Required: exactly 54 accepted reads, address/read held during stalls; triangles 0..2 from 0x1C, 0x40, 0x64 match the memory model.
- Backpressure:
  - Stimulus: i_ready held low 10 cycles on triangle 1 of 2.
  - Required: o_tri/o_tri_index stable, no Avalon reads issued meanwhile; triangle 1 index=1 accepted once.
- Reset mid-run:
  - Stimulus: reset after 7 accepted reads, with stale readdatavalid pulses afterwards; then restart with cnt=1.
  - Required: all outputs 0 after reset; stale data ignored; restarted triangle bit-exact.
- Start while busy plus address wrap:
  - Stimulus: i_start pulsed during ISSUE; base=0xFFFFFFF8, cnt=1.
  - Required: the extra start is ignored; addresses wrap to 0x00000000..0x0000001A.
